// File: rtl/wb_mon_pkg.sv
// Shared types for the Wishbone classic-cycle protocol monitor.
// Error codes double as bit indices into the sticky error vector.
package wb_mon_pkg;

  localparam int NUM_ERR = 6;

  typedef enum logic [2:0] {
    ERR_RST_STB    = 3'd0,
    ERR_STB_NO_CYC = 3'd1,
    ERR_UNSTABLE   = 3'd2,
    ERR_STB_DROP   = 3'd3,
    ERR_SPUR_ACK   = 3'd4,
    ERR_TIMEOUT    = 3'd5
  } err_code_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  // Lowest set bit wins when several rules break in the same cycle.
  function automatic err_code_e first_err(input logic [NUM_ERR-1:0] v);
    first_err = ERR_RST_STB;
    for (int i = NUM_ERR - 1; i >= 0; i--)
      if (v[i]) first_err = err_code_e'(i[2:0]);
  endfunction

endpackage

// File: rtl/wb_mon_sat_counter.sv
// Saturating event counter; a clear that coincides with an event restarts at one.
module wb_mon_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= W'(inc);
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 classic-cycle checker: flags protocol violations,
// records the first one, and keeps transaction counters and worst ack latency.
module wb_protocol_monitor
  import wb_mon_pkg::*;
#(
  parameter int AW          = 26,
  parameter int DW          = 32,
  parameter int SW          = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16,
  parameter int LAT_W       = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [SW-1:0]      wb_sel_i,
  input  logic [AW-1:0]      wb_addr_i,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               clr_i,
  output logic               busy_o,
  output logic               err_pulse_o,
  output logic [NUM_ERR-1:0] err_sticky_o,
  output logic               err_valid_o,
  output logic [2:0]         first_err_code_o,
  output logic [AW-1:0]      first_err_addr_o,
  output logic [CNT_W-1:0]   rd_cnt_o,
  output logic [CNT_W-1:0]   wr_cnt_o,
  output logic [CNT_W-1:0]   abort_cnt_o,
  output logic [LAT_W-1:0]   max_lat_o
);

  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(ACK_TIMEOUT);

  state_e             state, state_nxt;
  logic               post_rst;
  logic [AW-1:0]      cap_addr;
  logic               cap_we;
  logic [SW-1:0]      cap_sel;
  logic [DW-1:0]      cap_dat;
  logic [LAT_W-1:0]   lat_cnt;
  logic               unstable_seen, timeout_seen;

  logic [NUM_ERR-1:0] err_vec;
  logic               any_err;
  logic               start, wait_cyc, done, done_we, abort, mismatch;
  logic [LAT_W-1:0]   done_lat;

  assign mismatch = (wb_addr_i != cap_addr) || (wb_we_i != cap_we) ||
                    (wb_sel_i != cap_sel) || (cap_we && (wb_dat_i != cap_dat));
  assign any_err  = |err_vec;
  assign busy_o   = (state == WAIT_ACK);

  always_comb begin
    state_nxt = state;
    err_vec   = '0;
    start     = 1'b0;
    wait_cyc  = 1'b0;
    done      = 1'b0;
    done_we   = wb_we_i;
    done_lat  = '0;
    abort     = 1'b0;

    err_vec[ERR_RST_STB]    = post_rst & wb_stb_i;
    err_vec[ERR_STB_NO_CYC] = wb_stb_i & ~wb_cyc_i;

    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (wb_ack_i) done = 1'b1;
          else begin
            start     = 1'b1;
            state_nxt = WAIT_ACK;
          end
        end else if (wb_ack_i) begin
          err_vec[ERR_SPUR_ACK] = 1'b1;
        end
      end
      WAIT_ACK: begin
        done_we = cap_we;
        if (!wb_cyc_i) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (!wb_stb_i) begin
          err_vec[ERR_STB_DROP] = 1'b1;
          state_nxt             = IDLE;
        end else if (wb_ack_i) begin
          done      = 1'b1;
          done_lat  = lat_cnt;
          state_nxt = IDLE;
        end else begin
          // Each rule reports at most once per transaction.
          wait_cyc              = 1'b1;
          err_vec[ERR_UNSTABLE] = mismatch & ~unstable_seen;
          err_vec[ERR_TIMEOUT]  = (lat_cnt == LAT_LIMIT) & ~timeout_seen;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      post_rst      <= 1'b1;
      cap_addr      <= '0;
      cap_we        <= 1'b0;
      cap_sel       <= '0;
      cap_dat       <= '0;
      lat_cnt       <= '0;
      unstable_seen <= 1'b0;
      timeout_seen  <= 1'b0;
    end else begin
      state    <= state_nxt;
      post_rst <= 1'b0;
      if (start) begin
        cap_addr      <= wb_addr_i;
        cap_we        <= wb_we_i;
        cap_sel       <= wb_sel_i;
        cap_dat       <= wb_dat_i;
        lat_cnt       <= LAT_W'(1);
        unstable_seen <= 1'b0;
        timeout_seen  <= 1'b0;
      end else if (wait_cyc) begin
        if (lat_cnt != LAT_LIMIT) lat_cnt <= lat_cnt + 1'b1;
        if (err_vec[ERR_UNSTABLE]) unstable_seen <= 1'b1;
        if (err_vec[ERR_TIMEOUT])  timeout_seen  <= 1'b1;
      end
    end
  end

  // Clear takes effect first so an error in the clearing cycle is still kept.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_pulse_o      <= 1'b0;
      err_sticky_o     <= '0;
      err_valid_o      <= 1'b0;
      first_err_code_o <= '0;
      first_err_addr_o <= '0;
      max_lat_o        <= '0;
    end else begin
      err_pulse_o  <= any_err;
      err_sticky_o <= (clr_i ? '0 : err_sticky_o) | err_vec;
      if (clr_i) begin
        err_valid_o      <= any_err;
        first_err_code_o <= any_err ? first_err(err_vec) : '0;
        first_err_addr_o <= any_err ? wb_addr_i : '0;
      end else if (!err_valid_o && any_err) begin
        err_valid_o      <= 1'b1;
        first_err_code_o <= first_err(err_vec);
        first_err_addr_o <= wb_addr_i;
      end
      if (clr_i)                               max_lat_o <= done ? done_lat : '0;
      else if (done && (done_lat > max_lat_o)) max_lat_o <= done_lat;
    end
  end

  wb_mon_sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .inc (done & ~done_we),
    .clr (clr_i),
    .cnt (rd_cnt_o)
  );

  wb_mon_sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .inc (done & done_we),
    .clr (clr_i),
    .cnt (wr_cnt_o)
  );

  wb_mon_sat_counter #(.W(CNT_W)) u_abort_cnt (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .inc (abort),
    .clr (clr_i),
    .cnt (abort_cnt_o)
  );

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Scoreboard bench for wb_protocol_monitor: expected outputs queued per step, checked after the edge.
module tb_wb_protocol_monitor;

  localparam int AW = 26, DW = 32, SW = 4, ACK_TIMEOUT = 64, CNT_W = 16, LAT_W = 8;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_i = 1'b0, clr_i = 1'b0;
  logic [SW-1:0]    wb_sel_i = 4'hF;
  logic [AW-1:0]    wb_addr_i = '0;
  logic [DW-1:0]    wb_dat_i = 32'hA5A5_0001;
  logic             busy_o, err_pulse_o, err_valid_o;
  logic [5:0]       err_sticky_o;
  logic [2:0]       first_err_code_o;
  logic [AW-1:0]    first_err_addr_o;
  logic [CNT_W-1:0] rd_cnt_o, wr_cnt_o, abort_cnt_o;
  logic [LAT_W-1:0] max_lat_o;

  wb_protocol_monitor #(
    .AW(AW), .DW(DW), .SW(SW), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W), .LAT_W(LAT_W)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .clr_i(clr_i), .busy_o(busy_o), .err_pulse_o(err_pulse_o),
    .err_sticky_o(err_sticky_o), .err_valid_o(err_valid_o), .first_err_code_o(first_err_code_o),
    .first_err_addr_o(first_err_addr_o), .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o),
    .abort_cnt_o(abort_cnt_o), .max_lat_o(max_lat_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef enum int {O_BUSY, O_PULSE, O_STICKY, O_VALID, O_CODE, O_ADDR, O_RD, O_WR, O_ABORT, O_LAT} obs_e;
  typedef struct {
    string       tag;
    obs_e        id;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];
  int  tests = 0, fails = 0;

  function automatic logic [63:0] obs(input obs_e id);
    case (id)
      O_BUSY:   obs = 64'(busy_o);
      O_PULSE:  obs = 64'(err_pulse_o);
      O_STICKY: obs = 64'(err_sticky_o);
      O_VALID:  obs = 64'(err_valid_o);
      O_CODE:   obs = 64'(first_err_code_o);
      O_ADDR:   obs = 64'(first_err_addr_o);
      O_RD:     obs = 64'(rd_cnt_o);
      O_WR:     obs = 64'(wr_cnt_o);
      O_ABORT:  obs = 64'(abort_cnt_o);
      default:  obs = 64'(max_lat_o);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e id, input logic [63:0] v);
    sb_t e;
    e.tag = tag; e.id = id; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic flush();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.id), e.exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic we, input logic ack,
                       input logic [AW-1:0] a);
    wb_cyc_i = c; wb_stb_i = s; wb_we_i = we; wb_ack_i = ack; wb_addr_i = a;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge wb_clk_i);
    #1;
    expect_out("rst_busy", O_BUSY, 0);   expect_out("rst_sticky", O_STICKY, 0);
    expect_out("rst_valid", O_VALID, 0); expect_out("rst_wr", O_WR, 0);
    expect_out("rst_lat", O_LAT, 0);     expect_out("rst_pulse", O_PULSE, 0);
    flush();

    // Strobe in the first post-reset cycle (cyc low also trips STB_NO_CYC)
    wb_rst_i = 1'b0;
    drive(0, 1, 0, 0, 26'h0);
    step();
    expect_out("rststb_sticky", O_STICKY, 6'b000011); expect_out("rststb_code", O_CODE, 0);
    expect_out("rststb_pulse", O_PULSE, 1);           expect_out("rststb_valid", O_VALID, 1);
    flush();
    drive(0, 0, 0, 0, 26'h0);
    step();
    expect_out("rststb_pulse_end", O_PULSE, 0); expect_out("rststb_keep", O_STICKY, 6'b000011);
    flush();
    clr_i = 1'b1; step(); clr_i = 1'b0;
    expect_out("clr1_sticky", O_STICKY, 0); expect_out("clr1_valid", O_VALID, 0);
    flush();

    // Write 0x10, ack on third wait cycle
    drive(1, 1, 1, 0, 26'h10);
    step();
    expect_out("wr_busy", O_BUSY, 1); flush();
    step(); step();
    wb_ack_i = 1'b1;
    step();
    expect_out("wr_cnt", O_WR, 1);       expect_out("wr_lat", O_LAT, 3);
    expect_out("wr_sticky", O_STICKY, 0); expect_out("wr_rd", O_RD, 0);
    expect_out("wr_busy_end", O_BUSY, 0);
    flush();
    drive(0, 0, 0, 0, 26'h0); step();

    // Read with address change at wait cycle 2
    drive(1, 1, 0, 0, 26'h20);
    step(); step();
    expect_out("unst_pre", O_STICKY, 0); flush();
    wb_addr_i = 26'h24;
    step();
    expect_out("unst_sticky", O_STICKY, 6'b000100); expect_out("unst_addr", O_ADDR, 26'h24);
    expect_out("unst_code", O_CODE, 2);             expect_out("unst_pulse", O_PULSE, 1);
    flush();
    wb_ack_i = 1'b1;
    step();
    expect_out("unst_rd", O_RD, 1); expect_out("unst_lat", O_LAT, 3);
    flush();
    drive(0, 0, 0, 0, 26'h0); step();

    // Read with no ack: timeout at wait cycle 64, then abort
    drive(1, 1, 0, 0, 26'h30);
    step();
    repeat (ACK_TIMEOUT - 1) step();
    expect_out("to_pre", O_STICKY, 6'b000100); flush();
    step();
    expect_out("to_sticky", O_STICKY, 6'b100100); expect_out("to_pulse", O_PULSE, 1);
    expect_out("to_busy", O_BUSY, 1);             expect_out("to_code", O_CODE, 2);
    flush();
    step();
    expect_out("to_once", O_PULSE, 0); flush();
    drive(0, 0, 0, 0, 26'h0);
    step();
    expect_out("abort_cnt", O_ABORT, 1); expect_out("abort_busy", O_BUSY, 0);
    expect_out("abort_noerr", O_PULSE, 0);
    flush();

    // Clear, then spurious ack with stb but no cyc
    clr_i = 1'b1; step(); clr_i = 1'b0;
    expect_out("clr2_sticky", O_STICKY, 0); expect_out("clr2_rd", O_RD, 0);
    expect_out("clr2_abort", O_ABORT, 0);   expect_out("clr2_lat", O_LAT, 0);
    expect_out("clr2_addr", O_ADDR, 0);
    flush();
    drive(0, 1, 0, 1, 26'h55);
    step();
    expect_out("spur_sticky", O_STICKY, 6'b010010); expect_out("spur_code", O_CODE, 1);
    expect_out("spur_addr", O_ADDR, 26'h55);
    flush();
    drive(0, 0, 0, 0, 26'h0); step();

    // Clear coinciding with a new error keeps the new error
    clr_i = 1'b1; drive(0, 1, 0, 0, 26'h66);
    step();
    clr_i = 1'b0; drive(0, 0, 0, 0, 26'h0);
    expect_out("clrerr_sticky", O_STICKY, 6'b000010); expect_out("clrerr_valid", O_VALID, 1);
    expect_out("clrerr_addr", O_ADDR, 26'h66);
    flush();

    // Ack exactly at the timeout cycle: no timeout, latency 64
    clr_i = 1'b1; step(); clr_i = 1'b0;
    drive(1, 1, 0, 0, 26'h40);
    step();
    repeat (ACK_TIMEOUT - 1) step();
    wb_ack_i = 1'b1;
    step();
    expect_out("edge_lat", O_LAT, 64); expect_out("edge_rd", O_RD, 1);
    expect_out("edge_sticky", O_STICKY, 0);
    flush();
    drive(0, 0, 0, 0, 26'h0); step();

    // Strobe dropped while cyc held
    drive(1, 1, 1, 0, 26'h70);
    step();
    wb_stb_i = 1'b0;
    step();
    expect_out("drop_sticky", O_STICKY, 6'b001000); expect_out("drop_code", O_CODE, 3);
    expect_out("drop_busy", O_BUSY, 0);             expect_out("drop_wr", O_WR, 0);
    flush();
    drive(0, 0, 0, 0, 26'h0); step();

    // Zero-wait write stream saturates the write counter
    clr_i = 1'b1; step(); clr_i = 1'b0;
    drive(1, 1, 1, 1, 26'h80);
    repeat (66000) step();
    expect_out("sat_wr", O_WR, 16'hFFFF); expect_out("sat_lat", O_LAT, 0);
    expect_out("sat_sticky", O_STICKY, 0);
    flush();
    drive(0, 0, 0, 0, 26'h0); step();

    // Reset mid-transaction discards it
    drive(1, 1, 0, 0, 26'h90);
    step();
    wb_rst_i = 1'b1;
    #1;
    expect_out("mrst_busy", O_BUSY, 0); expect_out("mrst_wr", O_WR, 0);
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
